// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite HTRANS/HBURST/HRESP codes, HPROT default, master FSM states and beat-count helpers
package ahb_lite_pkg;
  localparam logic [1:0] HT_IDLE = 2'b00, HT_BUSY = 2'b01, HT_NONSEQ = 2'b10, HT_SEQ = 2'b11;
  localparam logic [2:0] HB_SINGLE = 3'd0, HB_INCR = 3'd1, HB_WRAP4 = 3'd2, HB_INCR4 = 3'd3;
  localparam logic [2:0] HB_WRAP8 = 3'd4, HB_INCR8 = 3'd5, HB_WRAP16 = 3'd6, HB_INCR16 = 3'd7;
  localparam logic HR_OKAY = 1'b0, HR_ERROR = 1'b1;
  localparam logic [3:0] HPROT_DEF = 4'b0011;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_DRAIN, S_ERR} state_t;
  function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [4:0] len);
    return burst == HB_SINGLE ? 5'd1 : burst == HB_INCR ? len :
           burst[2:1] == 2'b01 ? 5'd4 : burst[2:1] == 2'b10 ? 5'd8 : 5'd16;
  endfunction
  function automatic logic is_wrap(input logic [2:0] burst);
    return !burst[0] && burst != HB_SINGLE;
  endfunction
endpackage

// File: rtl/ahb_lite_burst_master_if.sv
// ahb_lite_burst_master_if: AHB-Lite bus (H*) plus cmd_*, wdata_* stream and rdata_*/done_* return signals; master/slave modports
interface ahb_lite_burst_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic HREADY, HRESP, HWRITE, HMASTLOCK;
  logic cmd_valid, cmd_ready, cmd_write, wdata_valid, wdata_ready;
  logic rdata_valid, rdata_last, done_valid, done_err;
  logic [DATA_W-1:0] HRDATA, HWDATA, wdata, rdata;
  logic [ADDR_W-1:0] HADDR, cmd_addr;
  logic [2:0] HSIZE, HBURST, cmd_size, cmd_burst;
  logic [3:0] HPROT;
  logic [1:0] HTRANS;
  logic [4:0] cmd_len;
  modport master (
    input HREADY, HRESP, HRDATA, cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wdata_valid, wdata,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA, cmd_ready, wdata_ready,
    rdata_valid, rdata, rdata_last, done_valid, done_err
  );
  modport slave (
    output HREADY, HRESP, HRDATA, cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst, cmd_len, wdata_valid, wdata,
    input HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HWDATA, cmd_ready, wdata_ready,
    rdata_valid, rdata, rdata_last, done_valid, done_err
  );
endinterface

// File: rtl/ahb_lite_addr_gen.sv
// ahb_lite_addr_gen: i_addr/i_size/i_burst -> o_next beat address (wrap-folded) and o_cross 1 KB crossing flag
module ahb_lite_addr_gen
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_size,
  input  logic [2:0]        i_burst,
  output logic [ADDR_W-1:0] o_next,
  output logic              o_cross
);
  logic [ADDR_W-1:0] w_sum, w_mask;
  always_comb begin
    w_sum = i_addr + (ADDR_W'(1) << i_size);
    w_mask = (ADDR_W'(burst_beats(i_burst, 5'd0)) << i_size) - ADDR_W'(1);
    o_next = is_wrap(i_burst) ? (i_addr & ~w_mask) | (w_sum & w_mask) : w_sum;
    o_cross = !is_wrap(i_burst) && (w_sum[ADDR_W-1:10] != i_addr[ADDR_W-1:10]);
  end
endmodule

// File: rtl/ahb_lite_burst_master.sv
// ahb_lite_burst_master: HCLK/HRESET plus master modport m (AHB-Lite bus, cmd/wdata inputs, rdata/done returns); pipelined burst master
module ahb_lite_burst_master
  import ahb_lite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_LEN = 16
) (
  input logic HCLK,
  input logic HRESET,
  ahb_lite_burst_master_if.master m
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W / 8));
  state_t r_state;
  logic [ADDR_W-1:0] r_addr, w_next;
  logic [DATA_W-1:0] r_hwdata, r_rdata;
  logic [4:0] r_left;
  logic [2:0] r_size, r_burst;
  logic [1:0] r_trans, w_trans;
  logic r_write, r_hold, r_dp, r_dp_last, r_rvalid, r_rlast, r_done, r_err;
  logic w_stall, w_go, w_bad, w_rv, w_cross;
  ahb_lite_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .i_addr(r_addr), .i_size(r_size), .i_burst(r_burst), .o_next(w_next), .o_cross(w_cross)
  );
  always_comb begin
    w_stall = r_write && !r_hold && !m.wdata_valid && r_trans[1];
    w_trans = w_stall ? (r_trans == HT_NONSEQ ? HT_IDLE : HT_BUSY) : r_trans;
    w_go = m.HREADY && w_trans[1];
    w_rv = m.HREADY && r_dp && !r_write && m.HRESP == HR_OKAY;
    w_bad = m.cmd_size > MAX_SIZE || (m.cmd_burst == HB_INCR && (m.cmd_len == 5'd0 || m.cmd_len > 5'(MAX_LEN)));
  end
  assign m.HADDR = r_addr;
  assign m.HWRITE = r_write;
  assign m.HSIZE = r_size;
  assign m.HBURST = r_burst;
  assign m.HPROT = HPROT_DEF;
  assign m.HTRANS = w_trans;
  assign m.HMASTLOCK = 1'b0;
  assign m.HWDATA = r_hwdata;
  assign m.cmd_ready = r_state == S_IDLE;
  assign m.wdata_ready = w_go && r_write;
  assign m.rdata_valid = r_rvalid;
  assign m.rdata = r_rdata;
  assign m.rdata_last = r_rlast;
  assign m.done_valid = r_done;
  assign m.done_err = r_err;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_hwdata <= '0;
      r_rdata <= '0;
      r_left <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_trans <= HT_IDLE;
      r_write <= 1'b0;
      r_hold <= 1'b0;
      r_dp <= 1'b0;
      r_dp_last <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_rvalid <= w_rv;
      r_rlast <= w_rv && r_dp_last;
      if (w_rv) r_rdata <= m.HRDATA;
      r_hold <= w_trans[1] && !m.HREADY;
      if (m.HREADY) r_dp <= w_go;
      if (w_go) begin
        r_dp_last <= r_left == 5'd1;
        r_left <= r_left - 5'd1;
        if (r_write) r_hwdata <= m.wdata;
      end
      case (r_state)
        S_IDLE: if (m.cmd_valid) begin
          if (w_bad) begin
            r_done <= 1'b1;
            r_err <= 1'b1;
          end else begin
            r_state <= S_ADDR;
            r_addr <= m.cmd_addr;
            r_write <= m.cmd_write;
            r_size <= m.cmd_size;
            r_burst <= m.cmd_burst;
            r_left <= burst_beats(m.cmd_burst, m.cmd_len);
            r_trans <= HT_NONSEQ;
          end
        end
        S_ADDR, S_BURST: if (r_dp && m.HRESP == HR_ERROR && !m.HREADY) begin
          r_state <= S_ERR;
          r_trans <= HT_IDLE;
        end else if (w_go) begin
          if (r_left == 5'd1) begin
            r_state <= S_DRAIN;
            r_trans <= HT_IDLE;
          end else begin
            r_state <= S_BURST;
            r_addr <= w_next;
            r_trans <= w_cross ? HT_NONSEQ : HT_SEQ;
            if (w_cross) r_burst <= HB_INCR;
          end
        end
        S_DRAIN: if (m.HRESP == HR_ERROR && !m.HREADY) r_state <= S_ERR;
          else if (m.HREADY) begin
            r_state <= S_IDLE;
            r_done <= 1'b1;
          end
        S_ERR: if (m.HREADY) begin
          r_state <= S_IDLE;
          r_done <= 1'b1;
          r_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
